alu_mdu_ctrl: RTL and testbench

Parametrised EX-stage control block for the pipelined MIPS core. It keeps the single-cycle ALU control decode (ALUOp/funct to a 4-bit ALU code) and adds an iterative multiply/divide unit (MDU) with HI/LO registers. The MDU runs a start/run/done state machine and stalls the pipeline while busy. It sits between the ID/EX register and the ALU/forwarding mux.

---
 rtl/alu_ctrl_pkg.sv | 59 +++++
 rtl/mdu_iter_core.sv | 94 +++++++++
 rtl/alu_mdu_ctrl.sv | 159 +++++++++++++++
 tb/tb_alu_mdu_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the EX-stage ALU control / multiply-divide block.
// Holds the ALU codes, funct codes, ALUOp classes, result-mux selects and MDU FSM states.
package alu_ctrl_pkg;

  localparam int DATA_W_DEF    = 32;
  localparam int FUNC_W_DEF    = 6;
  localparam int ALUOP_W_DEF   = 2;
  localparam int ALUCTRL_W_DEF = 4;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_NONE  = 2'b11;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_F14  = 4'b1000;
  localparam logic [3:0] ALU_NOR  = 4'b1100;
  localparam logic [3:0] ALU_NONE = 4'b1111;

  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_XOR   = 6'b100110;
  localparam logic [5:0] FN_NOR   = 6'b100111;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_F14   = 6'b010100;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MTHI  = 6'b010001;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MTLO  = 6'b010011;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;

  typedef enum logic [1:0] {
    SEL_ALU = 2'b00,
    SEL_HI  = 2'b01,
    SEL_LO  = 2'b10
  } result_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } mdu_state_e;

  // MULT/MULTU/DIV/DIVU share the 0110xx pattern; bit1 = divide, bit0 = unsigned.
  function automatic logic is_mdu_func(input logic [5:0] f);
    return f[5:2] == 4'b0110;
  endfunction

endpackage

// File: rtl/mdu_iter_core.sv
// Iterative multiply (shift-add) / restoring-divide datapath with HI/LO registers.
// Sequenced by load/step/finish strobes from alu_mdu_ctrl; works on magnitudes, fixes signs on finish.
module mdu_iter_core
  import alu_ctrl_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              load_i,
  input  logic              step_i,
  input  logic              finish_i,
  input  logic              is_div_i,
  input  logic              is_signed_i,
  input  logic [DATA_W-1:0] rs_i,
  input  logic [DATA_W-1:0] rt_i,
  input  logic              wr_hi_i,
  input  logic              wr_lo_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  logic              div_q, neg_q, rneg_q;
  logic [DATA_W-1:0] mcand_q, acc_q, wrk_q, hi_q, lo_q;

  logic              rs_neg, rt_neg;
  logic [DATA_W-1:0] rs_mag, rt_mag;
  logic [DATA_W:0]   add_sum, shifted;
  logic              ge;
  logic [DATA_W-1:0] acc_step, wrk_step, quot_fix, rem_fix;
  logic [2*DATA_W-1:0] prod, prod_fix;

  assign rs_neg = is_signed_i & rs_i[DATA_W-1];
  assign rt_neg = is_signed_i & rt_i[DATA_W-1];
  assign rs_mag = rs_neg ? -rs_i : rs_i;
  assign rt_mag = rt_neg ? -rt_i : rt_i;

  // Multiply: {acc,wrk} shifts right, multiplier bits leave wrk LSB.
  // Divide: dividend bits leave wrk MSB into the remainder, quotient bits enter wrk LSB.
  assign add_sum = {1'b0, acc_q} + (wrk_q[0] ? {1'b0, mcand_q} : '0);
  assign shifted = {acc_q, wrk_q[DATA_W-1]};
  assign ge      = shifted >= {1'b0, mcand_q};

  always_comb begin
    acc_step = add_sum[DATA_W:1];
    wrk_step = {add_sum[0], wrk_q[DATA_W-1:1]};
    if (div_q) begin
      acc_step = ge ? DATA_W'(shifted - {1'b0, mcand_q}) : shifted[DATA_W-1:0];
      wrk_step = {wrk_q[DATA_W-2:0], ge};
    end
  end

  assign prod     = {acc_step, wrk_step};
  assign prod_fix = neg_q ? -prod : prod;
  assign quot_fix = neg_q ? -wrk_step : wrk_step;
  assign rem_fix  = rneg_q ? -acc_step : acc_step;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      div_q   <= 1'b0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      mcand_q <= '0;
      acc_q   <= '0;
      wrk_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      if (load_i) begin
        div_q   <= is_div_i;
        neg_q   <= rs_neg ^ rt_neg;
        rneg_q  <= rs_neg;
        mcand_q <= rt_mag;
        acc_q   <= '0;
        wrk_q   <= rs_mag;
      end else if (step_i) begin
        acc_q <= acc_step;
        wrk_q <= wrk_step;
      end
      if (finish_i) begin
        hi_q <= div_q ? rem_fix : prod_fix[2*DATA_W-1:DATA_W];
        lo_q <= div_q ? quot_fix : prod_fix[DATA_W-1:0];
      end else begin
        if (wr_hi_i) hi_q <= wdata_i;
        if (wr_lo_i) lo_q <= wdata_i;
      end
    end
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule

// File: rtl/alu_mdu_ctrl.sv
// EX-stage ALU control decode plus iterative MULT/DIV unit with HI/LO and pipeline stall.
// Optional MTHI/MTLO support is enabled by defining MDU_MTHILO_EN.
module alu_mdu_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int FUNC_W    = FUNC_W_DEF,
  parameter int ALUOP_W   = ALUOP_W_DEF,
  parameter int ALUCTRL_W = ALUCTRL_W_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 valid_i,
  input  logic [ALUOP_W-1:0]   ALUOp_i,
  input  logic [FUNC_W-1:0]    func_i,
  input  logic [DATA_W-1:0]    rs_data_i,
  input  logic [DATA_W-1:0]    rt_data_i,
  input  logic                 flush_i,
  output logic [ALUCTRL_W-1:0] ALU_control_o,
  output logic [1:0]           result_sel_o,
  output logic                 stall_o,
  output logic                 done_o,
  output logic                 div_by_zero_o,
  output logic [DATA_W-1:0]    hi_o,
  output logic [DATA_W-1:0]    lo_o
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  logic [5:0]  fn;
  logic [1:0]  op;
  logic [3:0]  alu_code;
  result_sel_e sel;
  mdu_state_e  state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic        dz_q, dz_d;
  logic        rtype, start, is_div, load, step, finish, wr_hi, wr_lo;

  assign fn     = 6'(func_i);
  assign op     = 2'(ALUOp_i);
  assign rtype  = op == ALUOP_RTYPE;
  assign is_div = fn[1];
  assign start  = valid_i & ~flush_i & rtype & is_mdu_func(fn) & (state_q == ST_IDLE);

  always_comb begin
    alu_code = ALU_NONE;
    sel      = SEL_ALU;
    case (op)
      ALUOP_ADD: alu_code = ALU_ADD;
      ALUOP_SUB: alu_code = ALU_SUB;
      ALUOP_RTYPE: begin
        case (fn)
          FN_ADD:  alu_code = ALU_ADD;
          FN_SUB:  alu_code = ALU_SUB;
          FN_AND:  alu_code = ALU_AND;
          FN_OR:   alu_code = ALU_OR;
          FN_XOR:  alu_code = ALU_XOR;
          FN_NOR:  alu_code = ALU_NOR;
          FN_SLT:  alu_code = ALU_SLT;
          FN_F14:  alu_code = ALU_F14;
          FN_MFHI: if (valid_i) sel = SEL_HI;
          FN_MFLO: if (valid_i) sel = SEL_LO;
          default: alu_code = ALU_NONE;
        endcase
      end
      default: alu_code = ALU_NONE;
    endcase
  end

  assign ALU_control_o = ALUCTRL_W'(alu_code);
  assign result_sel_o  = sel;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dz_d    = dz_q;
    load    = 1'b0;
    step    = 1'b0;
    finish  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          load = 1'b1;
          // A zero divisor retires immediately, leaving HI/LO untouched.
          if (is_div && rt_data_i == '0) begin
            dz_d    = 1'b1;
            state_d = ST_DONE;
          end else begin
            dz_d    = 1'b0;
            cnt_d   = CNT_W'(DATA_W - 1);
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (flush_i) begin
          state_d = ST_IDLE;
        end else begin
          step = 1'b1;
          if (cnt_q == '0) begin
            finish  = 1'b1;
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      ST_DONE: begin
        dz_d    = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dz_q    <= dz_d;
    end
  end

`ifdef MDU_MTHILO_EN
  assign wr_hi = valid_i & ~flush_i & rtype & (fn == FN_MTHI) & (state_q == ST_IDLE);
  assign wr_lo = valid_i & ~flush_i & rtype & (fn == FN_MTLO) & (state_q == ST_IDLE);
`else
  assign wr_hi = 1'b0;
  assign wr_lo = 1'b0;
`endif

  mdu_iter_core #(
    .DATA_W(DATA_W)
  ) u_core (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .load_i     (load),
    .step_i     (step),
    .finish_i   (finish),
    .is_div_i   (is_div),
    .is_signed_i(~fn[0]),
    .rs_i       (rs_data_i),
    .rt_i       (rt_data_i),
    .wr_hi_i    (wr_hi),
    .wr_lo_i    (wr_lo),
    .wdata_i    (rs_data_i),
    .hi_o       (hi_o),
    .lo_o       (lo_o)
  );

  assign stall_o       = (start | (state_q == ST_RUN)) & ~flush_i & rst_n_i;
  assign done_o        = state_q == ST_DONE;
  assign div_by_zero_o = (state_q == ST_DONE) & dz_q;

endmodule

// File: tb/tb_alu_mdu_ctrl.sv
// Self-checking bench for alu_mdu_ctrl: decode table, MULT/DIV scoreboard, divide-by-zero, flush, reset.
module tb_alu_mdu_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        valid_i;
  logic [1:0]  ALUOp_i;
  logic [5:0]  func_i;
  logic [31:0] rs_data_i, rt_data_i;
  logic        flush_i;
  logic [3:0]  ALU_control_o;
  logic [1:0]  result_sel_o;
  logic        stall_o, done_o, div_by_zero_o;
  logic [31:0] hi_o, lo_o;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] m_hi, m_lo;
  int          checks   = 0;
  int          failures = 0;

  always #5 clk_i = ~clk_i;

  alu_mdu_ctrl dut (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .valid_i      (valid_i),
    .ALUOp_i      (ALUOp_i),
    .func_i       (func_i),
    .rs_data_i    (rs_data_i),
    .rt_data_i    (rt_data_i),
    .flush_i      (flush_i),
    .ALU_control_o(ALU_control_o),
    .result_sel_o (result_sel_o),
    .stall_o      (stall_o),
    .done_o       (done_o),
    .div_by_zero_o(div_by_zero_o),
    .hi_o         (hi_o),
    .lo_o         (lo_o)
  );

  // Reference model built on SystemVerilog 64-bit arithmetic, independent of the iterative datapath.
  task automatic model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                       output exp_t e);
    longint sa, sb, q, r;
    logic [63:0] p;
    if (f[0]) begin
      sa = longint'({32'h0, a});
      sb = longint'({32'h0, b});
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end
    e.hi = m_hi;
    e.lo = m_lo;
    e.dz = 1'b0;
    if (!f[1]) begin
      p    = 64'(sa * sb);
      e.hi = p[63:32];
      e.lo = p[31:0];
    end else if (b == 32'h0) begin
      e.dz = 1'b1;
    end else begin
      q    = sa / sb;
      r    = sa % sb;
      e.hi = r[31:0];
      e.lo = q[31:0];
    end
  endtask

  // Called just after a rising edge; returns just after a rising edge.
  task automatic run_op(input string name, input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, input int exp_stalls, input bit keep);
    exp_t e, g;
    int   stalls;
    bit   got;
    model(f, a, b, e);
    sb_q.push_back(e);
    m_hi = e.hi;
    m_lo = e.lo;
    valid_i = 1'b1; ALUOp_i = 2'b10; func_i = f; rs_data_i = a; rt_data_i = b;
    stalls = 0;
    got    = 1'b0;
    for (int c = 0; c < 200 && !got; c++) begin
      @(negedge clk_i);
      if (done_o) got = 1'b1;
      else if (stall_o) stalls++;
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL %s timeout: done_o never seen, stalls=%0d required %0d", name, stalls, exp_stalls);
      void'(sb_q.pop_front());
    end else begin
      g = sb_q.pop_front();
      checks += 4;
      if (stalls !== exp_stalls) begin
        failures++;
        $display("FAIL %s stall_cycles got=%0d exp=%0d", name, stalls, exp_stalls);
      end
      if (hi_o !== g.hi) begin
        failures++;
        $display("FAIL %s hi got=%h exp=%h", name, hi_o, g.hi);
      end
      if (lo_o !== g.lo) begin
        failures++;
        $display("FAIL %s lo got=%h exp=%h", name, lo_o, g.lo);
      end
      if (div_by_zero_o !== g.dz) begin
        failures++;
        $display("FAIL %s div_by_zero got=%b exp=%b", name, div_by_zero_o, g.dz);
      end
      $display("txn %s rs=%h rt=%h stalls=%0d hi=%h lo=%h dz=%b", name, a, b, stalls, hi_o, lo_o,
               div_by_zero_o);
    end
    @(posedge clk_i); #1;
    if (!keep) valid_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0; valid_i = 1'b1; ALUOp_i = 2'b10; func_i = 6'b011000;
    rs_data_i = 32'd5; rt_data_i = 32'd3; flush_i = 1'b0;
    m_hi = 32'h0; m_lo = 32'h0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    checks += 4;
    if (stall_o !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall_o); end
    if (done_o !== 1'b0 || div_by_zero_o !== 1'b0) begin
      failures++; $display("FAIL reset_done got=%b%b exp=00", done_o, div_by_zero_o);
    end
    if (hi_o !== 32'h0) begin failures++; $display("FAIL reset_hi got=%h exp=0", hi_o); end
    if (lo_o !== 32'h0) begin failures++; $display("FAIL reset_lo got=%h exp=0", lo_o); end
    $display("txn reset stall=%b done=%b hi=%h lo=%h", stall_o, done_o, hi_o, lo_o);
    valid_i = 1'b0;
    rst_n_i = 1'b1;
    @(posedge clk_i); #1;
  endtask

  task automatic test_decode();
    logic [1:0] t_op[15]  = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10,
                              2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10};
    logic [5:0] t_fn[15]  = '{6'b100010, 6'b100000, 6'b011000, 6'b100000, 6'b100010, 6'b100100,
                              6'b100101, 6'b100110, 6'b100111, 6'b101010, 6'b010100, 6'b011010,
                              6'b010000, 6'b010010, 6'b111111};
    logic       t_v[15]   = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 1, 1, 1};
    logic [3:0] t_code[15] = '{4'b0010, 4'b0110, 4'b1111, 4'b0010, 4'b0110, 4'b0000, 4'b0001,
                               4'b0011, 4'b1100, 4'b0111, 4'b1000, 4'b1111, 4'b1111, 4'b1111,
                               4'b1111};
    logic [1:0] t_sel[15] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00,
                              2'b00, 2'b00, 2'b00, 2'b01, 2'b10, 2'b00};
    for (int i = 0; i < 15; i++) begin
      ALUOp_i = t_op[i]; func_i = t_fn[i]; valid_i = t_v[i];
      #1;
      checks += 3;
      if (ALU_control_o !== t_code[i]) begin
        failures++; $display("FAIL decode[%0d] alu_ctrl got=%b exp=%b", i, ALU_control_o, t_code[i]);
      end
      if (result_sel_o !== t_sel[i]) begin
        failures++; $display("FAIL decode[%0d] result_sel got=%b exp=%b", i, result_sel_o, t_sel[i]);
      end
      if (stall_o !== 1'b0) begin
        failures++; $display("FAIL decode[%0d] stall got=%b exp=0", i, stall_o);
      end
      $display("txn decode op=%b fn=%b v=%b ctrl=%b sel=%b", t_op[i], t_fn[i], t_v[i],
               ALU_control_o, result_sel_o);
    end
    ALUOp_i = 2'b10; func_i = 6'b010010; valid_i = 1'b0;
    #1;
    checks++;
    if (result_sel_o !== 2'b00) begin
      failures++; $display("FAIL decode_mflo_invalid result_sel got=%b exp=00", result_sel_o);
    end
    @(posedge clk_i); #1;
  endtask

  task automatic test_mthilo();
    logic [31:0] eh, el;
    valid_i = 1'b1; ALUOp_i = 2'b10; func_i = 6'b010001; rs_data_i = 32'hDEADBEEF;
    @(negedge clk_i);
    checks++;
    if (stall_o !== 1'b0) begin failures++; $display("FAIL mthi_stall got=%b exp=0", stall_o); end
    @(posedge clk_i); #1;
    func_i = 6'b010011; rs_data_i = 32'hCAFEF00D;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
`ifdef MDU_MTHILO_EN
    m_hi = 32'hDEADBEEF; m_lo = 32'hCAFEF00D;
`endif
    eh = m_hi; el = m_lo;
    checks += 2;
    if (hi_o !== eh) begin failures++; $display("FAIL mthi_hi got=%h exp=%h", hi_o, eh); end
    if (lo_o !== el) begin failures++; $display("FAIL mtlo_lo got=%h exp=%h", lo_o, el); end
    $display("txn mthi/mtlo hi=%h lo=%h", hi_o, lo_o);
  endtask

  task automatic test_mult();
    run_op("MULT_-2x3", 6'b011000, 32'hFFFFFFFE, 32'd3, 33, 1'b0);
    run_op("MULTU_max2", 6'b011001, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 1'b0);
    run_op("MULT_rand", 6'b011000, 32'h8765_4321, 32'h0ABC_DEF1, 33, 1'b0);
  endtask

  task automatic test_div();
    run_op("DIV_-7/2", 6'b011010, 32'hFFFFFFF9, 32'd2, 33, 1'b0);
    run_op("DIVU_7/2", 6'b011011, 32'd7, 32'd2, 33, 1'b0);
    run_op("DIV_min/-1", 6'b011010, 32'h80000000, 32'hFFFFFFFF, 33, 1'b0);
    run_op("DIV_100/-7", 6'b011010, 32'd100, 32'hFFFFFFF9, 33, 1'b0);
  endtask

  task automatic test_divzero();
    run_op("MULTU_setup", 6'b011001, 32'h12345678, 32'h00010001, 33, 1'b0);
    run_op("DIVU_7/0", 6'b011011, 32'd7, 32'd0, 1, 1'b0);
    run_op("DIV_-5/0", 6'b011010, 32'hFFFFFFFB, 32'd0, 1, 1'b0);
  endtask

  task automatic test_flush();
    int dones;
    valid_i = 1'b1; ALUOp_i = 2'b10; func_i = 6'b011000;
    rs_data_i = 32'd1234; rt_data_i = 32'd5678;
    repeat (10) @(posedge clk_i);
    #1 flush_i = 1'b1;
    @(negedge clk_i);
    checks++;
    if (stall_o !== 1'b0) begin failures++; $display("FAIL flush_stall got=%b exp=0", stall_o); end
    @(posedge clk_i); #1;
    flush_i = 1'b0; valid_i = 1'b0;
    dones = 0;
    repeat (3) begin @(negedge clk_i); if (done_o || stall_o) dones++; end
    checks += 3;
    if (dones !== 0) begin failures++; $display("FAIL flush_no_done got=%0d exp=0", dones); end
    if (hi_o !== m_hi) begin failures++; $display("FAIL flush_hi got=%h exp=%h", hi_o, m_hi); end
    if (lo_o !== m_lo) begin failures++; $display("FAIL flush_lo got=%h exp=%h", lo_o, m_lo); end
    $display("txn flush hi=%h lo=%h", hi_o, lo_o);
    @(posedge clk_i); #1;
    run_op("MULT_after_flush", 6'b011000, 32'hFFFFFF00, 32'h00000101, 33, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_op("B2B_MULT1", 6'b011000, 32'd300, 32'hFFFFFFF0, 33, 1'b1);
    run_op("B2B_MULT2", 6'b011000, 32'h7FFFFFFF, 32'h7FFFFFFF, 33, 1'b1);
    run_op("B2B_DIVU", 6'b011011, 32'hFFFFFFFF, 32'd10, 33, 1'b0);
  endtask

  task automatic test_async_reset();
    valid_i = 1'b1; ALUOp_i = 2'b10; func_i = 6'b011001;
    rs_data_i = 32'h00FF00FF; rt_data_i = 32'h00000100;
    repeat (5) @(posedge clk_i);
    #3 rst_n_i = 1'b0;
    #1;
    checks += 4;
    if (hi_o !== 32'h0) begin failures++; $display("FAIL async_rst_hi got=%h exp=0", hi_o); end
    if (lo_o !== 32'h0) begin failures++; $display("FAIL async_rst_lo got=%h exp=0", lo_o); end
    if (stall_o !== 1'b0) begin failures++; $display("FAIL async_rst_stall got=%b exp=0", stall_o); end
    if (done_o !== 1'b0) begin failures++; $display("FAIL async_rst_done got=%b exp=0", done_o); end
    $display("txn async_reset hi=%h lo=%h stall=%b", hi_o, lo_o, stall_o);
    m_hi = 32'h0; m_lo = 32'h0;
    valid_i = 1'b0;
    @(negedge clk_i);
    rst_n_i = 1'b1;
    @(posedge clk_i); #1;
    run_op("MULTU_after_rst", 6'b011001, 32'h00FF00FF, 32'h00000100, 33, 1'b0);
  endtask

  initial begin
    test_reset();
    test_decode();
    test_mthilo();
    test_mult();
    test_div();
    test_divzero();
    test_flush();
    test_back_to_back();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
